bbox_scan_engine: RTL

- Parametrised successor to the single-image bounding-box top.
- Scans a WIDTH x HEIGHT frame held in external synchronous RAM and classifies each pixel as foreground when every colour channel falls inside a per-channel [lo, hi] window.
- Reports the tight bounding box (x_min, x_max, y_min, y_max) of all foreground pixels, with a start/busy/done handshake.
- Sits between the frame RAM and downstream overlay/control logic.

---
 rtl/bbox_scan_engine.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/bbox_scan_engine.sv
// rtl/bbox_scan_engine.sv - raster-scan colour-window bounding-box engine over an external sync RAM
// Optional foreground pixel counter enabled by BBOX_AREA_COUNT_EN.
module bbox_scan_engine #(
  parameter int IMG_W  = 320,
  parameter int IMG_H  = 240,
  parameter int NUM_CH = 3,
  parameter int CH_W   = 8,
  parameter int ADDR_W = $clog2(IMG_W*IMG_H),
  parameter int X_W    = $clog2(IMG_W),
  parameter int Y_W    = $clog2(IMG_H)
) (
  input  logic                     CLOCK_50,
  input  logic                     reset,
  input  logic                     start,
  input  logic [NUM_CH*CH_W-1:0]   thresh_lo,
  input  logic [NUM_CH*CH_W-1:0]   thresh_hi,
  output logic                     mem_rd,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic [NUM_CH*CH_W-1:0]   mem_rdata,
  output logic                     busy,
  output logic                     done,
  output logic                     found,
  output logic [X_W-1:0]           x_min,
  output logic [X_W-1:0]           x_max,
  output logic [Y_W-1:0]           y_min,
  output logic [Y_W-1:0]           y_max
`ifdef BBOX_AREA_COUNT_EN
  ,
  output logic [ADDR_W:0]          fg_count
`endif
);

  localparam int NPIX = IMG_W * IMG_H;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
  localparam logic [X_W-1:0]    X_LAST    = X_W'(IMG_W - 1);
  localparam logic [Y_W-1:0]    Y_LAST    = Y_W'(IMG_H - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  state_t state, state_next;
  logic   accept;

  logic [NUM_CH*CH_W-1:0] lo_q, hi_q;
  logic [X_W-1:0] cur_x, tag_x;
  logic [Y_W-1:0] cur_y, tag_y;
  logic           tag_vld;
  logic           hit;
  logic           found_n;
  logic [X_W-1:0] x_min_n, x_max_n;
  logic [Y_W-1:0] y_min_n, y_max_n;

  always_ff @(posedge CLOCK_50) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = SCAN;
        end
      end
      SCAN:    if (mem_addr == LAST_ADDR) state_next = DRAIN;
      DRAIN:   state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  // tag_* lines up with mem_rdata: both refer to the address driven one cycle earlier
  always_comb begin
    hit = tag_vld;
    for (int c = 0; c < NUM_CH; c++) begin
      if (mem_rdata[c*CH_W +: CH_W] < lo_q[c*CH_W +: CH_W] ||
          mem_rdata[c*CH_W +: CH_W] > hi_q[c*CH_W +: CH_W])
        hit = 1'b0;
    end
  end

  always_comb begin
    found_n = found | hit;
    x_min_n = (hit && tag_x < x_min) ? tag_x : x_min;
    x_max_n = (hit && tag_x > x_max) ? tag_x : x_max;
    y_min_n = (hit && tag_y < y_min) ? tag_y : y_min;
    y_max_n = (hit && tag_y > y_max) ? tag_y : y_max;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      lo_q     <= '0;
      hi_q     <= '0;
      cur_x    <= '0;
      cur_y    <= '0;
      tag_x    <= '0;
      tag_y    <= '0;
      tag_vld  <= 1'b0;
      mem_rd   <= 1'b0;
      mem_addr <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      found    <= 1'b0;
      x_min    <= '0;
      x_max    <= '0;
      y_min    <= '0;
      y_max    <= '0;
    end else begin
      tag_vld <= mem_rd;
      tag_x   <= cur_x;
      tag_y   <= cur_y;
      if (accept) begin
        lo_q     <= thresh_lo;
        hi_q     <= thresh_hi;
        done     <= 1'b0;
        found    <= 1'b0;
        x_min    <= X_LAST;
        y_min    <= Y_LAST;
        x_max    <= '0;
        y_max    <= '0;
        mem_addr <= '0;
        mem_rd   <= 1'b1;
        busy     <= 1'b1;
        cur_x    <= '0;
        cur_y    <= '0;
      end else begin
        if (state == SCAN) begin
          if (mem_addr == LAST_ADDR) begin
            mem_rd <= 1'b0;
          end else begin
            mem_addr <= mem_addr + 1'b1;
            if (cur_x == X_LAST) begin
              cur_x <= '0;
              cur_y <= cur_y + 1'b1;
            end else begin
              cur_x <= cur_x + 1'b1;
            end
          end
        end
        if (state == SCAN || state == DRAIN) begin
          found <= found_n;
          x_min <= x_min_n;
          x_max <= x_max_n;
          y_min <= y_min_n;
          y_max <= y_max_n;
        end
        // The last pixel lands on the same edge that raises done
        if (state == DRAIN) begin
          busy <= 1'b0;
          done <= 1'b1;
          if (!found_n) begin
            x_min <= '0;
            x_max <= '0;
            y_min <= '0;
            y_max <= '0;
          end
        end
      end
    end
  end

`ifdef BBOX_AREA_COUNT_EN
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      fg_count <= '0;
    end else if (accept) begin
      fg_count <= '0;
    end else if ((state == SCAN || state == DRAIN) && hit &&
                 fg_count != (ADDR_W+1)'(NPIX)) begin
      fg_count <= fg_count + 1'b1;
    end
  end
`endif

endmodule
